mul_sched: RTL and testbench

- Shares one shift-add multiplier instance (`multiplier`, M×N, load-by-reset style) among NREQ requesters.
- Round-robin arbitration grants one requester at a time.
- Drives the multiplier's load line and operands, counts its fixed latency, captures the product, and returns it tagged with the requester index.
- Sits between requester blocks and the single multiplier in the arithmetic subsystem.

---
 rtl/mul_pkg.sv | 16 +
 rtl/mul_sched_rr_arbiter.sv | 30 +++
 rtl/mul_sched.sv | 127 ++++++++++++
 tb/tb_mul_sched.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and defaults for the multiplier scheduler.
package mul_pkg;

  localparam int unsigned M_DEF       = 8;
  localparam int unsigned N_DEF       = 8;
  // The shift-add multiplier needs one cycle per Q bit plus one to settle.
  localparam int unsigned MUL_LAT_DEF = N_DEF + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mul_sched_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or above ptr, wrapping at NREQ.
module mul_sched_rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  always_comb begin
    int unsigned j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < int'(NREQ); k++) begin
      j = 32'(ptr) + 32'(k);
      if (j >= NREQ) j = j - NREQ;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/mul_sched.sv
// Time-shares one shift-add multiplier among NREQ requesters with round-robin
// arbitration; results return tagged with the owning requester index.
module mul_sched
  import mul_pkg::*;
#(
  parameter int unsigned M        = M_DEF,
  parameter int unsigned N        = N_DEF,
  parameter int unsigned NREQ     = 4,
  parameter int unsigned LOAD_CYC = 1,
  parameter int unsigned MUL_LAT  = MUL_LAT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*M-1:0]       req_d,
  input  logic [NREQ*N-1:0]       req_q,
  output logic                    mul_load,
  output logic [M-1:0]            mul_d,
  output logic [N-1:0]            mul_q,
  input  logic [M+N-1:0]          mul_out,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [M+N-1:0]          rsp_prod,
  output logic                    busy
);

  localparam int unsigned IDW  = $clog2(NREQ);
  localparam int unsigned CMAX = (LOAD_CYC > MUL_LAT) ? LOAD_CYC : MUL_LAT;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  state_t           state, state_n;
  logic [CW-1:0]    counter, counter_n;
  logic [IDW-1:0]   rr_ptr, rr_ptr_n;
  logic [M-1:0]     op_d, op_d_n;
  logic [N-1:0]     op_q, op_q_n;
  logic [IDW-1:0]   rsp_id_n;
  logic [M+N-1:0]   rsp_prod_n;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   gidx;
  logic             gany;

  mul_sched_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (gany)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      counter  <= '0;
      rr_ptr   <= '0;
      op_d     <= '0;
      op_q     <= '0;
      rsp_id   <= '0;
      rsp_prod <= '0;
    end else begin
      state    <= state_n;
      counter  <= counter_n;
      rr_ptr   <= rr_ptr_n;
      op_d     <= op_d_n;
      op_q     <= op_q_n;
      rsp_id   <= rsp_id_n;
      rsp_prod <= rsp_prod_n;
    end
  end

  // Next-state and grant logic
  always_comb begin
    state_n    = state;
    counter_n  = counter;
    rr_ptr_n   = rr_ptr;
    op_d_n     = op_d;
    op_q_n     = op_q;
    rsp_id_n   = rsp_id;
    rsp_prod_n = rsp_prod;
    req_ready  = '0;
    unique case (state)
      S_IDLE: begin
        req_ready = grant;
        if (gany) begin
          op_d_n    = req_d[32'(gidx) * M +: M];
          op_q_n    = req_q[32'(gidx) * N +: N];
          rsp_id_n  = gidx;
          counter_n = CW'(LOAD_CYC - 1);
          state_n   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (counter == '0) begin
          counter_n = CW'(MUL_LAT - 1);
          state_n   = S_RUN;
        end else begin
          counter_n = counter - CW'(1);
        end
      end
      S_RUN: begin
        if (counter == '0) begin
          rsp_prod_n = mul_out;
          state_n    = S_DONE;
        end else begin
          counter_n = counter - CW'(1);
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          rr_ptr_n = (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + IDW'(1);
          state_n  = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign mul_load  = (state == S_LOAD);
  assign mul_d     = op_d;
  assign mul_q     = op_q;
  assign rsp_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_mul_sched.sv
// Scoreboard bench for mul_sched with a behavioural fixed-latency multiplier.
module tb_mul_sched;

  localparam int unsigned M    = 8;
  localparam int unsigned N    = 8;
  localparam int unsigned NREQ = 4;
  localparam int unsigned LC   = 1;
  localparam int unsigned ML   = 9;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req_valid;
  logic [3:0]      req_ready;
  logic [31:0]     req_d;
  logic [31:0]     req_q;
  logic            mul_load;
  logic [7:0]      mul_d;
  logic [7:0]      mul_q;
  logic [15:0]     mul_out;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [15:0]     rsp_prod;
  logic            busy;

  always #5 clk = ~clk;

  mul_sched #(.M(M), .N(N), .NREQ(NREQ), .LOAD_CYC(LC), .MUL_LAT(ML)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_d     (req_d),
    .req_q     (req_q),
    .mul_load  (mul_load),
    .mul_d     (mul_d),
    .mul_q     (mul_q),
    .mul_out   (mul_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_prod  (rsp_prod),
    .busy      (busy)
  );

  // Multiplier model: operands latched while load is high, product valid ML cycles after it falls
  logic [7:0] ma = 8'h0;
  logic [7:0] mb = 8'h0;
  int unsigned mcnt = 1000;
  always @(posedge clk) begin
    if (mul_load) begin
      ma   <= mul_d;
      mb   <= mul_q;
      mcnt <= 0;
    end else if (mcnt < 1000) begin
      mcnt <= mcnt + 1;
    end
  end
  assign mul_out = (!mul_load && mcnt >= ML - 1) ? 16'(ma) * 16'(mb) : 16'h0000;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] prod;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc     = 0;
  int unsigned acc_cyc = 0;
  int unsigned load_run = 0;
  int unsigned n_acc   = 0;
  logic        prev_rv = 1'b0;
  logic [1:0]  m_ptr   = 2'd0;

  // Monitor: reference round-robin grant, scoreboard push/pop, pulse width and latency
  always @(negedge clk) begin
    exp_t       e;
    logic [1:0] gid;
    logic [1:0] j;
    logic [3:0] goh;
    logic       found;
    cyc++;
    if (!rst) begin
      exp_q.delete();
      m_ptr    = 2'd0;
      load_run = 0;
      prev_rv  = 1'b0;
    end else begin
      if (mul_load) load_run++;
      else if (load_run != 0) begin
        check("load_width", load_run, 32'(LC));
        load_run = 0;
      end
      if (rsp_valid && !prev_rv) check("latency", cyc - acc_cyc, 32'(LC + ML + 1));
      prev_rv = rsp_valid;
      if (|req_valid) begin
        if (busy) check("ready_busy", 32'(req_ready), 32'h0);
        else begin
          found = 1'b0;
          gid   = 2'd0;
          goh   = 4'b0000;
          for (int k = 0; k < 4; k++) begin
            j = m_ptr + 2'(k);
            if (!found && req_valid[j]) begin
              found  = 1'b1;
              gid    = j;
              goh[j] = 1'b1;
            end
          end
          check("grant", 32'(req_ready), 32'(goh));
          e.id   = gid;
          e.prod = 16'(req_d[32'(gid)*8 +: 8]) * 16'(req_q[32'(gid)*8 +: 8]);
          exp_q.push_back(e);
          acc_cyc = cyc;
          n_acc++;
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) check("spurious_rsp", 32'h1, 32'h0);
        else begin
          e = exp_q.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(e.id));
          check("rsp_prod", 32'(rsp_prod), 32'(e.prod));
          m_ptr = e.id + 2'd1;
        end
      end
    end
  end

  task automatic set_op(input int id, input logic [7:0] d, input logic [7:0] q);
    req_d[id*8 +: 8] = d;
    req_q[id*8 +: 8] = q;
  endtask

  task automatic issue(input int id, input logic [7:0] d, input logic [7:0] q);
    logic ok;
    ok = 1'b0;
    @(posedge clk); #1;
    set_op(id, d, q);
    req_valid[id] = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (!busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    int unsigned start;
    logic ok;
    rst       = 1'b0;
    req_valid = 4'b0000;
    req_d     = 32'h0;
    req_q     = 32'h0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_mul_load", 32'(mul_load), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rsp_id", 32'(rsp_id), 32'h0);
    check("rst_rsp_prod", 32'(rsp_prod), 32'h0);
    check("rst_mul_d", 32'(mul_d), 32'h0);
    check("rst_mul_q", 32'(mul_q), 32'h0);
    rst = 1'b1;

    // Fairness: all four valid continuously, expect grants 0,1,2,3,0
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) set_op(i, 8'(i + 1), 8'd3);
    start     = n_acc;
    req_valid = 4'b1111;
    ok        = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (n_acc >= start + 5) begin
        ok = 1'b1;
        break;
      end
    end
    req_valid = 4'b0000;
    if (!ok) check("fair_timeout", 32'h0, 32'h1);
    wait_idle();

    issue(0, 8'hFF, 8'hFF);
    wait_idle();

    // A request raised and dropped while busy must never be served
    issue(2, 8'h0F, 8'h87);
    req_valid[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    wait_idle();
    repeat (5) @(posedge clk);
    #1;
    check("dropped_req_busy", 32'(busy), 32'h0);

    issue(1, 8'h00, 8'hFF);
    wait_idle();
    issue(2, 8'h80, 8'h02);
    wait_idle();

    // Backpressure in DONE with another requester waiting
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    issue(3, 8'h55, 8'h03);
    set_op(0, 8'd2, 8'd2);
    req_valid[0] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("bp_timeout", 32'h0, 32'h1);
    repeat (20) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      check("bp_rsp_prod", 32'(rsp_prod), 32'h00FF);
      check("bp_rsp_id", 32'(rsp_id), 32'h3);
      check("bp_busy", 32'(busy), 32'h1);
      check("bp_mul_load", 32'(mul_load), 32'h0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_busy", 32'(busy), 32'h0);
    check("bp_release_valid", 32'(rsp_valid), 32'h0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_idle();

    // Leave the pointer at 3, then reset during RUN
    issue(2, 8'h11, 8'h11);
    wait_idle();
    @(posedge clk); #1;
    set_op(3, 8'd5, 8'd5);
    req_valid[3] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (busy) req_valid[3] = 1'b0;
      if (busy && !mul_load) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("run_timeout", 32'h0, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("mid_rst_mul_load", 32'(mul_load), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    set_op(1, 8'd0, 8'hAB);
    set_op(3, 8'h22, 8'h33);
    start     = n_acc;
    req_valid = 4'b1010;
    ok        = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (n_acc > start) begin
        ok = 1'b1;
        break;
      end
    end
    req_valid = 4'b0000;
    if (!ok) check("post_rst_timeout", 32'h0, 32'h1);
    wait_idle();

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
